// File: rtl/serial_adder_ctrl_pkg.sv
// serial_adder_ctrl_pkg: FSM state encoding and WIDTH range check for the bit-serial adder
package serial_adder_ctrl_pkg;
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;
    localparam int WIDTH_MIN = 2;
    localparam int WIDTH_MAX = 32;
    function automatic bit width_ok(input int w);
        return (w >= WIDTH_MIN) && (w <= WIDTH_MAX);
    endfunction
endpackage

// File: rtl/serial_adder_ctrl_fa.sv
// serial_adder_ctrl_fa: single-bit full_adder cell composed from two half adders
module half_adder (
    input  logic i_a,
    input  logic i_b,
    output logic o_s,
    output logic o_c
);
    assign o_s = i_a ^ i_b;
    assign o_c = i_a & i_b;
endmodule

module full_adder (
    input  logic i_a,
    input  logic i_b,
    input  logic i_cin,
    output logic o_s,
    output logic o_cout
);
    logic w_s1, w_c1, w_c2;
    half_adder u_ha0 (.i_a(i_a),  .i_b(i_b),   .o_s(w_s1), .o_c(w_c1));
    half_adder u_ha1 (.i_a(w_s1), .i_b(i_cin), .o_s(o_s),  .o_c(w_c2));
    assign o_cout = w_c1 | w_c2;
endmodule

// File: rtl/serial_adder_ctrl.sv
// serial_adder_ctrl: bit-serial add/subtract, one full_adder stepped LSB-first over WIDTH clocks
module serial_adder_ctrl
    import serial_adder_ctrl_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic             out_ovf,
    output logic             busy
);
    localparam int CNT_W = $clog2(WIDTH) + 1;

    generate
        if (!width_ok(WIDTH)) begin : g_bad_width
            $error("serial_adder_ctrl: WIDTH out of range 2..32");
        end
    endgenerate

    state_t             r_state, w_next;
    logic [WIDTH-1:0]   r_a, r_b, r_sum;
    logic               r_carry, r_cmsb;
    logic [CNT_W-1:0]   r_cnt;
    logic               w_s, w_co, w_last;

    full_adder u_fa (.i_a(r_a[0]), .i_b(r_b[0]), .i_cin(r_carry), .o_s(w_s), .o_cout(w_co));

    assign w_last = (r_cnt == CNT_W'(WIDTH - 1));

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: w_next = in_valid  ? ST_RUN  : ST_IDLE;
            ST_RUN:  w_next = w_last    ? ST_DONE : ST_RUN;
            ST_DONE: w_next = out_ready ? ST_IDLE : ST_DONE;
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_IDLE;
        else r_state <= w_next;
    end

    // Subtract presets carry=1 and inverts B so the same cell computes A + ~B + 1
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a     <= '0;
            r_b     <= '0;
            r_sum   <= '0;
            r_carry <= 1'b0;
            r_cmsb  <= 1'b0;
            r_cnt   <= '0;
        end else if (r_state == ST_IDLE && in_valid) begin
            r_a     <= in_a;
            r_b     <= in_b ^ {WIDTH{in_sub}};
            r_carry <= in_sub;
            r_cnt   <= '0;
        end else if (r_state == ST_RUN) begin
            r_a     <= {1'b0, r_a[WIDTH-1:1]};
            r_b     <= {1'b0, r_b[WIDTH-1:1]};
            r_sum   <= {w_s, r_sum[WIDTH-1:1]};
            r_carry <= w_co;
            r_cnt   <= r_cnt + CNT_W'(1);
            if (w_last) r_cmsb <= r_carry;
        end
    end

    assign in_ready  = (r_state == ST_IDLE);
    assign busy      = (r_state != ST_IDLE);
    assign out_valid = (r_state == ST_DONE);
    assign out_sum   = r_sum;
    assign out_cout  = r_carry;
    assign out_ovf   = r_cmsb ^ r_carry;
endmodule

// File: tb/tb_serial_adder_ctrl.sv
// tb_serial_adder_ctrl: directed table vectors plus backpressure, ignore-in-RUN and reset corner cases
module tb_serial_adder_ctrl;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] in_a = '0;
    logic [W-1:0] in_b = '0;
    logic         in_sub = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] out_sum;
    logic         out_cout;
    logic         out_ovf;
    logic         busy;

    int n_vec = 0;
    int n_bad = 0;

    serial_adder_ctrl #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_sub(in_sub),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_sum(out_sum), .out_cout(out_cout), .out_ovf(out_ovf),
        .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] a, b;
        logic         sub;
        logic [W-1:0] sum;
        logic         cout, ovf;
    } vec_t;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    // Called at the negedge after the accepting edge; lat counts edges since accept
    task automatic wait_valid(input int start, output int lat);
        lat = start;
        while (!out_valid && lat < 40) begin
            @(posedge clk);
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub);
        @(negedge clk);
        in_a = a; in_b = b; in_sub = sub; in_valid = 1'b1;
        check("ready_before_accept", 32'(in_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        check("busy_after_accept", 32'(busy), 32'd1);
    endtask

    task automatic check_result(input string nm, input logic [W-1:0] s, input logic c, input logic o);
        check({nm, "_sum"},  32'(out_sum),  32'(s));
        check({nm, "_cout"}, 32'(out_cout), 32'(c));
        check({nm, "_ovf"},  32'(out_ovf),  32'(o));
    endtask

    task automatic release_result();
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        check("valid_cleared", 32'(out_valid), 32'd0);
        check("ready_in_idle", 32'(in_ready), 32'd1);
    endtask

    initial begin
        vec_t vecs[9];
        int lat;
        logic [W-1:0] hs;
        logic hc, ho;
        vecs[0] = '{a: 8'h35, b: 8'h4A, sub: 1'b0, sum: 8'h7F, cout: 1'b0, ovf: 1'b0};
        vecs[1] = '{a: 8'h7F, b: 8'h01, sub: 1'b0, sum: 8'h80, cout: 1'b0, ovf: 1'b1};
        vecs[2] = '{a: 8'hFF, b: 8'h01, sub: 1'b0, sum: 8'h00, cout: 1'b1, ovf: 1'b0};
        vecs[3] = '{a: 8'h10, b: 8'h20, sub: 1'b1, sum: 8'hF0, cout: 1'b0, ovf: 1'b0};
        vecs[4] = '{a: 8'h80, b: 8'h01, sub: 1'b1, sum: 8'h7F, cout: 1'b1, ovf: 1'b1};
        vecs[5] = '{a: 8'h00, b: 8'h00, sub: 1'b1, sum: 8'h00, cout: 1'b1, ovf: 1'b0};
        vecs[6] = '{a: 8'hAA, b: 8'h55, sub: 1'b0, sum: 8'hFF, cout: 1'b0, ovf: 1'b0};
        vecs[7] = '{a: 8'h80, b: 8'h80, sub: 1'b0, sum: 8'h00, cout: 1'b1, ovf: 1'b1};
        vecs[8] = '{a: 8'h7F, b: 8'hFF, sub: 1'b1, sum: 8'h80, cout: 1'b0, ovf: 1'b1};

        #12;
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_busy",  32'(busy),      32'd0);
        check_result("rst", 8'h00, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_ready", 32'(in_ready), 32'd1);

        for (int i = 0; i < 9; i++) begin
            start_op(vecs[i].a, vecs[i].b, vecs[i].sub);
            check("run_ready_low", 32'(in_ready), 32'd0);
            wait_valid(0, lat);
            check($sformatf("v%0d_latency", i), 32'(lat), 32'(W));
            check_result($sformatf("v%0d", i), vecs[i].sum, vecs[i].cout, vecs[i].ovf);
            release_result();
        end

        // Backpressure with in_valid held high throughout
        @(negedge clk);
        in_a = 8'h35; in_b = 8'h4A; in_sub = 1'b0; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_a = 8'h01; in_b = 8'h01;
        wait_valid(0, lat);
        check("bp_latency", 32'(lat), 32'(W));
        hs = out_sum; hc = out_cout; ho = out_ovf;
        check_result("bp_first", 8'h7F, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            @(negedge clk);
            check("bp_valid_hold", 32'(out_valid), 32'd1);
            check("bp_ready_low",  32'(in_ready),  32'd0);
            check_result("bp_stable", hs, hc, ho);
        end
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        check("bp_idle_valid", 32'(out_valid), 32'd0);
        check("bp_idle_ready", 32'(in_ready),  32'd1);
        check("bp_idle_busy",  32'(busy),      32'd0);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        check("bp_second_accept", 32'(busy), 32'd1);
        wait_valid(0, lat);
        check("bp_second_latency", 32'(lat), 32'(W));
        check_result("bp_second", 8'h02, 1'b0, 1'b0);
        release_result();

        // Operand changes during RUN must be ignored
        start_op(8'h35, 8'h4A, 1'b0);
        repeat (3) begin
            @(posedge clk);
            @(negedge clk);
        end
        in_a = 8'hFF; in_b = 8'hFF; in_sub = 1'b1; in_valid = 1'b1;
        wait_valid(3, lat);
        in_valid = 1'b0;
        check("ign_latency", 32'(lat), 32'(W));
        check_result("ign", 8'h7F, 1'b0, 1'b0);
        release_result();

        // Asynchronous reset in the middle of RUN
        start_op(8'hFF, 8'hFF, 1'b0);
        repeat (3) @(posedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("arst_valid", 32'(out_valid), 32'd0);
        check("arst_busy",  32'(busy),      32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk);
            @(negedge clk);
            check("arst_no_stale", 32'(out_valid | busy), 32'd0);
        end
        start_op(8'h01, 8'h01, 1'b0);
        wait_valid(0, lat);
        check("arst_next_latency", 32'(lat), 32'(W));
        check_result("arst_next", 8'h02, 1'b0, 1'b0);
        release_result();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
